// File: rtl/lsu_mem_port.sv
// Load/store unit between the core datapath and the single-port memory bus.
// Handles byte/half/word/dword accesses with lane alignment, write masks,
// sign/zero-extended loads, misalignment rejection and a response timeout.
module lsu_mem_port #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [XLEN-1:0]   resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_n;

  // Registered request attributes needed while the access is in flight.
  logic [1:0]        size_q;
  logic [1:0]        size_n;
  logic              uns_q;
  logic              uns_n;
  logic [OFF_W-1:0]  off_q;
  logic [OFF_W-1:0]  off_n;

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;

  logic              req_ready_n;
  logic              resp_valid_n;
  logic              resp_err_n;
  logic [XLEN-1:0]   resp_rdata_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [XLEN-1:0]   mem_wdata_n;
  logic [NB-1:0]     mem_wmask_n;
  logic              mem_read_n;
  logic              mem_write_n;

  logic              bad_c;
  logic [NB-1:0]     lane_base_c;
  logic [NB-1:0]     wmask_c;
  logic [XLEN-1:0]   wdata_rep_c;
  logic [ADDR_W-1:0] addr_al_c;
  logic [XLEN-1:0]   shifted_c;
  logic [XLEN-1:0]   load_c;
  logic              expire_c;

  // Decode the incoming request: legality, lane mask, replicated data, aligned address.
  always_comb begin
    bad_c       = 1'b0;
    lane_base_c = NB'(1);
    wdata_rep_c = req_wdata;
    case (req_size)
      2'd0: begin
        bad_c       = 1'b0;
        lane_base_c = NB'(1);
        wdata_rep_c = {(XLEN/8){req_wdata[7:0]}};
      end
      2'd1: begin
        bad_c       = req_addr[0];
        lane_base_c = NB'(3);
        wdata_rep_c = {(XLEN/16){req_wdata[15:0]}};
      end
      2'd2: begin
        bad_c       = (req_addr[1:0] != 2'd0);
        lane_base_c = NB'(15);
        wdata_rep_c = {(XLEN/32){req_wdata[31:0]}};
      end
      default: begin
        // dword only exists on a 64-bit datapath
        bad_c       = (XLEN == 32) || (req_addr[2:0] != 3'd0);
        lane_base_c = NB'(255);
        wdata_rep_c = req_wdata;
      end
    endcase
    wmask_c   = lane_base_c << req_addr[OFF_W-1:0];
    addr_al_c = req_addr;
    addr_al_c[OFF_W-1:0] = '0;
  end

  // Shift the returned lane down and extend it to the full register width.
  always_comb begin
    shifted_c = mem_rdata >> {off_q, 3'b000};
    load_c    = shifted_c;
    case (size_q)
      2'd0: begin
        if (uns_q) load_c = XLEN'(shifted_c[7:0]);
        else       load_c = XLEN'($signed(shifted_c[7:0]));
      end
      2'd1: begin
        if (uns_q) load_c = XLEN'(shifted_c[15:0]);
        else       load_c = XLEN'($signed(shifted_c[15:0]));
      end
      2'd2: begin
        if (uns_q) load_c = XLEN'(shifted_c[31:0]);
        else       load_c = XLEN'($signed(shifted_c[31:0]));
      end
      default: load_c = shifted_c;
    endcase
  end

  // Fires on the last ACCESS cycle the memory is allowed before the access is abandoned.
  always_comb begin
    expire_c = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    size_n       = size_q;
    uns_n        = uns_q;
    off_n        = off_q;
    cnt_n        = cnt;
    req_ready_n  = 1'b0;
    resp_valid_n = 1'b0;
    resp_err_n   = 1'b0;
    resp_rdata_n = '0;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    mem_wmask_n  = mem_wmask;
    mem_read_n   = mem_read;
    mem_write_n  = mem_write;

    case (state)
      S_IDLE: begin
        req_ready_n = 1'b1;
        if (req_valid) begin
          req_ready_n = 1'b0;
          size_n      = req_size;
          uns_n       = req_unsigned;
          off_n       = req_addr[OFF_W-1:0];
          if (bad_c) begin
            state_n      = S_RESP;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
          end else begin
            state_n     = S_ACCESS;
            cnt_n       = '0;
            mem_addr_n  = addr_al_c;
            mem_wdata_n = wdata_rep_c;
            mem_wmask_n = req_write ? wmask_c : '0;
            mem_read_n  = ~req_write;
            mem_write_n = req_write;
          end
        end
      end

      S_ACCESS: begin
        if (mem_resp) begin
          state_n      = S_RESP;
          resp_valid_n = 1'b1;
          resp_rdata_n = mem_write ? '0 : load_c;
          mem_read_n   = 1'b0;
          mem_write_n  = 1'b0;
          mem_wmask_n  = '0;
        end else if (expire_c) begin
          state_n      = S_RESP;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b1;
          mem_read_n   = 1'b0;
          mem_write_n  = 1'b0;
          mem_wmask_n  = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_RESP: begin
        state_n     = S_IDLE;
        req_ready_n = 1'b1;
      end

      default: begin
        state_n     = S_IDLE;
        req_ready_n = 1'b1;
        mem_read_n  = 1'b0;
        mem_write_n = 1'b0;
        mem_wmask_n = '0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Registered outputs and in-flight request attributes.
  always_ff @(posedge clk) begin
    if (rst) begin
      size_q     <= '0;
      uns_q      <= 1'b0;
      off_q      <= '0;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      size_q     <= size_n;
      uns_q      <= uns_n;
      off_q      <= off_n;
      cnt        <= cnt_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_err   <= resp_err_n;
      resp_rdata <= resp_rdata_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_wmask  <= mem_wmask_n;
      mem_read   <= mem_read_n;
      mem_write  <= mem_write_n;
    end
  end

endmodule
